transpose_row_feeder: RTL and testbench

//  Upstream feeder/controller for the N x N transpose buffer. Takes one sample per

---
 rtl/transpose_row_feeder.sv | 136 +++++++++++++
 tb/tb_transpose_row_feeder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/transpose_row_feeder.sv
// Row assembler and load/unload sequencer for an N x N transpose buffer.
// Optional input level shift is enabled by defining TRF_LEVEL_SHIFT_EN.
module transpose_row_feeder #(
  parameter int WIDTH    = 32,
  parameter int N        = 32,
  parameter int PIX_BITS = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        s_valid,
  input  logic [WIDTH-1:0]            s_data,
  output logic                        s_ready,
  output logic [N*WIDTH-1:0]          row_out,
  output logic                        load,
  output logic                        unload,
  output logic                        col_valid,
  output logic [$clog2(N)-1:0]        col_idx,
  output logic                        block_done
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST   = CW'(N - 1);
  localparam logic [CW-1:0] PENULT = CW'(N - 2);
  localparam logic [WIDTH-1:0] OFFS = WIDTH'(1) << (PIX_BITS - 1);

`ifdef TRF_LEVEL_SHIFT_EN
  localparam bit LS_EN = 1'b1;
`else
  localparam bit LS_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    FILL,
    LOAD,
    UNLOAD
  } state_t;

  state_t               r_state;
  logic [CW-1:0]        r_col_cnt;
  logic [CW-1:0]        r_row_cnt;
  logic [CW-1:0]        r_unl_cnt;
  logic [N*WIDTH-1:0]   r_row;
  logic                 r_s_ready;
  logic                 r_load;
  logic                 r_unload;
  logic                 r_block_done;

  logic                 w_accept;
  logic [WIDTH-1:0]     w_shift;
  logic [WIDTH-1:0]     w_elem;

  // Unsigned pixel minus mid-scale; WIDTH-bit wrap yields the sign extension.
  assign w_shift  = {{(WIDTH-PIX_BITS){1'b0}}, s_data[PIX_BITS-1:0]} - OFFS;
  assign w_elem   = LS_EN ? w_shift : s_data;
  assign w_accept = s_valid & r_s_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= FILL;
      r_col_cnt    <= '0;
      r_row_cnt    <= '0;
      r_unl_cnt    <= '0;
      r_row        <= '0;
      r_s_ready    <= 1'b1;
      r_load       <= 1'b0;
      r_unload     <= 1'b0;
      r_block_done <= 1'b0;
    end else if (flush) begin
      r_state      <= FILL;
      r_col_cnt    <= '0;
      r_row_cnt    <= '0;
      r_unl_cnt    <= '0;
      r_s_ready    <= 1'b1;
      r_load       <= 1'b0;
      r_unload     <= 1'b0;
      r_block_done <= 1'b0;
    end else begin
      r_load       <= 1'b0;
      r_block_done <= 1'b0;
      unique case (r_state)
        FILL: begin
          if (w_accept) begin
            r_row[r_col_cnt*WIDTH +: WIDTH] <= w_elem;
            if (r_col_cnt == LAST) begin
              r_col_cnt <= '0;
              r_state   <= LOAD;
              r_load    <= 1'b1;
              r_s_ready <= 1'b0;
            end else begin
              r_col_cnt <= r_col_cnt + 1'b1;
            end
          end
        end
        LOAD: begin
          if (r_row_cnt == LAST) begin
            r_row_cnt    <= '0;
            r_unl_cnt    <= '0;
            r_state      <= UNLOAD;
            r_unload     <= 1'b1;
            r_block_done <= (N == 1);
          end else begin
            r_row_cnt <= r_row_cnt + 1'b1;
            r_state   <= FILL;
            r_s_ready <= 1'b1;
          end
        end
        UNLOAD: begin
          if (r_unl_cnt == LAST) begin
            r_unl_cnt <= '0;
            r_state   <= FILL;
            r_unload  <= 1'b0;
            r_s_ready <= 1'b1;
          end else begin
            r_unl_cnt    <= r_unl_cnt + 1'b1;
            r_block_done <= (r_unl_cnt == PENULT);
          end
        end
        default: begin
          r_state   <= FILL;
          r_s_ready <= 1'b1;
          r_unload  <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready    = r_s_ready;
  assign row_out    = r_row;
  assign load       = r_load;
  assign unload     = r_unload;
  assign col_valid  = r_unload;
  assign col_idx    = r_unl_cnt;
  assign block_done = r_block_done;

endmodule

// File: tb/tb_transpose_row_feeder.sv
// Directed bench for transpose_row_feeder; captured load rows stand in
// for the transpose buffer so column contents can be checked on unload.
module tb_transpose_row_feeder;

  localparam int W = 32;
  localparam int N = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             s_valid = 1'b0;
  logic [W-1:0]     s_data = '0;
  logic             s_ready;
  logic [N*W-1:0]   row_out;
  logic             load;
  logic             unload;
  logic             col_valid;
  logic [4:0]       col_idx;
  logic             block_done;

  int checks = 0;
  int errors = 0;
  int nloads = 0;
  logic [W-1:0] cap [N][N];

  transpose_row_feeder #(.WIDTH(W), .N(N), .PIX_BITS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .row_out    (row_out),
    .load       (load),
    .unload     (unload),
    .col_valid  (col_valid),
    .col_idx    (col_idx),
    .block_done (block_done)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] elem(input int k);
    return row_out[k*W +: W];
  endfunction

  // Advance to the next falling edge; a row seen on load is latched
  // into the model of the transpose buffer.
  task automatic tick();
    @(negedge clk);
    if (load === 1'b1) begin
      for (int k = 0; k < N; k++) cap[nloads % N][k] = elem(k);
      nloads++;
    end
  endtask

  task automatic push(input logic [W-1:0] d, input int idle);
    for (int i = 0; i < idle; i++) tick();
    s_valid = 1'b1;
    s_data  = d;
    for (int t = 0; ; t++) begin
      if (t == 200) begin
        checks++; errors++;
        $display("FAIL push_timeout data=%0d got no accept required accept", d);
        break;
      end
      if (s_ready === 1'b1) begin
        tick();
        break;
      end
      tick();
    end
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    tick(); tick();
    rst = 1'b0;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_s_ready got %b required 1", s_ready); end
    checks++; if (load !== 1'b0) begin errors++; $display("FAIL rst_load got %b required 0", load); end
    checks++; if (unload !== 1'b0) begin errors++; $display("FAIL rst_unload got %b required 0", unload); end
    checks++; if (col_valid !== 1'b0) begin errors++; $display("FAIL rst_col_valid got %b required 0", col_valid); end
    checks++; if (col_idx !== 5'd0) begin errors++; $display("FAIL rst_col_idx got %0d required 0", col_idx); end
    checks++; if (block_done !== 1'b0) begin errors++; $display("FAIL rst_block_done got %b required 0", block_done); end
    checks++; if (row_out !== '0) begin errors++; $display("FAIL rst_row_out got nonzero required 0"); end
  endtask

  task automatic test_first_row();
    int bad;
    nloads = 0;
    for (int c = 0; c < N-1; c++) push(c, 0);
    checks++; if (load !== 1'b0) begin errors++; $display("FAIL early_load got %b required 0", load); end
    push(N-1, 0);
    checks++; if (load !== 1'b1) begin errors++; $display("FAIL row_load got %b required 1", load); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL load_s_ready got %b required 0", s_ready); end
    bad = -1;
    for (int k = 0; k < N; k++) if (elem(k) !== W'(k) && bad < 0) bad = k;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL row_elems k=%0d got %0d required %0d", bad, elem(bad), bad);
    end
    tick();
    checks++; if (load !== 1'b0) begin errors++; $display("FAIL load_len got %b required 0", load); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL ready_back got %b required 1", s_ready); end
  endtask

  task automatic test_flush_idle();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL flush_idle_ready got %b required 1", s_ready); end
    checks++; if (load !== 1'b0) begin errors++; $display("FAIL flush_idle_load got %b required 0", load); end
  endtask

  task automatic test_block(input string tag, input bit gaps);
    logic ctrl_ok;
    int bad_r;
    nloads = 0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) push(W'(100*r + c), gaps ? ((r*3 + c) % 2) : 0);
      checks++;
      if (load !== 1'b1) begin
        errors++;
        $display("FAIL %s_row_load r=%0d got %b required 1", tag, r, load);
      end
    end
    checks++;
    if (nloads != N) begin
      errors++;
      $display("FAIL %s_nloads got %0d required %0d", tag, nloads, N);
    end
    for (int c = 0; c < N; c++) begin
      tick();
      ctrl_ok = (unload === 1'b1) && (col_valid === 1'b1) && (load === 1'b0) &&
                (s_ready === 1'b0) && (col_idx === 5'(c)) &&
                (block_done === (c == N-1));
      checks++;
      if (!ctrl_ok) begin
        errors++;
        $display("FAIL %s_unl_ctrl c=%0d got unl=%b cv=%b ld=%b rdy=%b idx=%0d bd=%b required unl=1 cv=1 ld=0 rdy=0 idx=%0d bd=%b",
                 tag, c, unload, col_valid, load, s_ready, col_idx, block_done, c, c == N-1);
      end
      bad_r = -1;
      for (int r = 0; r < N; r++) if (cap[r][c] !== W'(100*r + c) && bad_r < 0) bad_r = r;
      checks++;
      if (bad_r >= 0) begin
        errors++;
        $display("FAIL %s_col c=%0d y%0d got %0d required %0d", tag, c, bad_r, cap[bad_r][c], 100*bad_r + c);
      end
    end
    tick();
    checks++;
    if (unload !== 1'b0 || col_valid !== 1'b0 || block_done !== 1'b0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_post got unl=%b cv=%b bd=%b rdy=%b required 0 0 0 1", tag, unload, col_valid, block_done, s_ready);
    end
  endtask

  task automatic test_flush();
    nloads = 0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < N; c++) push(W'(100*r + c), 0);
    for (int c = 0; c < 10; c++) push(W'(500 + c), 0);
    flush   = 1'b1;
    s_valid = 1'b1;
    s_data  = 999;
    tick();
    flush   = 1'b0;
    s_valid = 1'b0;
    checks++; if (load !== 1'b0) begin errors++; $display("FAIL flush_load got %b required 0", load); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %b required 1", s_ready); end
    checks++; if (elem(10) !== 32'd410) begin errors++; $display("FAIL flush_drop got %0d required 410", elem(10)); end
    checks++; if (elem(9) !== 32'd509) begin errors++; $display("FAIL flush_keep got %0d required 509", elem(9)); end
    test_block("after_flush", 1'b0);
  endtask

  task automatic test_reset_mid();
    nloads = 0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) push(W'(100*r + c), 0);
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (unload !== 1'b1 || col_idx !== 5'd7) begin
      errors++;
      $display("FAIL mid_reach got unl=%b idx=%0d required unl=1 idx=7", unload, col_idx);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (unload !== 1'b0 || col_valid !== 1'b0 || block_done !== 1'b0 || col_idx !== 5'd0) begin
      errors++;
      $display("FAIL mid_rst got unl=%b cv=%b bd=%b idx=%0d required 0 0 0 0", unload, col_valid, block_done, col_idx);
    end
    tick();
    rst = 1'b0;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready got %b required 1", s_ready); end
    test_block("after_rst", 1'b0);
  endtask

  task automatic test_level_shift();
    logic [W-1:0] din [4];
    logic [W-1:0] exp [4];
    din[0] = 32'd0;   din[1] = 32'd128;
    din[2] = 32'd255; din[3] = 32'hFFFF_FF00;
`ifdef TRF_LEVEL_SHIFT_EN
    exp[0] = 32'hFFFF_FF80; exp[1] = 32'd0;
    exp[2] = 32'd127;       exp[3] = 32'hFFFF_FF80;
`else
    exp[0] = 32'd0;   exp[1] = 32'd128;
    exp[2] = 32'd255; exp[3] = 32'hFFFF_FF00;
`endif
    for (int i = 0; i < 4; i++) push(din[i], 0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (elem(i) !== exp[i]) begin
        errors++;
        $display("FAIL lvl_shift k=%0d got %h required %h", i, elem(i), exp[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_row();
    test_flush_idle();
    test_block("full", 1'b0);
    test_block("gaps", 1'b1);
    test_flush();
    test_reset_mid();
    test_level_shift();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
